// File: rtl/step_sequencer.sv
// Sequencing controller for the add-by-STEP counter: debounces the button, paces auto ticks,
// and turns requests into single-cycle inc/clr commands plus the LIMIT celebration pulse.
module step_sequencer #(
    parameter int WIDTH           = 8,
    parameter int STEP            = 10,
    parameter int LIMIT           = 150,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_raw,
    input  logic             selec,
    input  logic             auto_en,
    input  logic             anim_busy,
    input  logic [WIDTH-1:0] count_in,
    output logic             inc_cmd,
    output logic             clr_cmd,
    output logic             count_reached,
    output logic [1:0]       state
);

    // state      | meaning
    // HOLD       | counter forced clear; one clr_cmd on entry, leave when selec=1
    // IDLE       | accepting manual/auto requests
    // SETTLE     | inc_cmd cycle plus one cycle for count_in to update
    // CELEBRATE  | clr_cmd+count_reached cycle, then wait out anim_busy (2 cycles min)
    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_CELEBRATE = 2'd3
    } state_t;

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [WIDTH-1:0]  LIMIT_W   = WIDTH'(LIMIT);

    if ((LIMIT % STEP) != 0) begin : g_limit_misaligned
        $error("step_sequencer: LIMIT must be a multiple of STEP");
    end

    state_t              state_q;
    logic                sync_q1;
    logic                sync_q2;
    logic                deb_level;
    logic                deb_level_d;
    logic [DEB_W-1:0]    deb_cnt;
    logic [AUTO_W-1:0]   auto_cnt;
    logic                boot_clr_done;
    logic                man_req;
    logic                auto_run;
    logic                auto_req;
    logic                req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            sync_q1     <= button_raw;
            sync_q2     <= sync_q1;
            deb_level_d <= deb_level;
            if (sync_q2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync_q2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign man_req  = deb_level & ~deb_level_d;
    assign auto_run = (state_q == ST_IDLE) && auto_en && selec;
    assign auto_req = auto_run && (auto_cnt == AUTO_LAST);
    assign req      = (man_req | auto_req) & ~anim_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt <= '0;
        end else if (!auto_run || auto_req || inc_cmd || clr_cmd) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // The command pulses double as first-cycle markers for SETTLE and CELEBRATE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HOLD;
            inc_cmd       <= 1'b0;
            clr_cmd       <= 1'b0;
            count_reached <= 1'b0;
            boot_clr_done <= 1'b0;
        end else begin
            inc_cmd       <= 1'b0;
            clr_cmd       <= 1'b0;
            count_reached <= 1'b0;
            if (state_q != ST_HOLD && !selec) begin
                // a clear already in flight covers the HOLD entry clear
                state_q       <= ST_HOLD;
                clr_cmd       <= ~clr_cmd;
                boot_clr_done <= 1'b1;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (!boot_clr_done) begin
                            clr_cmd       <= 1'b1;
                            boot_clr_done <= 1'b1;
                        end else if (selec) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (req) begin
                            if (count_in >= LIMIT_W) begin
                                clr_cmd       <= 1'b1;
                                count_reached <= 1'b1;
                                state_q       <= ST_CELEBRATE;
                            end else begin
                                inc_cmd <= 1'b1;
                                state_q <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (!inc_cmd) state_q <= ST_IDLE;
                    end
                    ST_CELEBRATE: begin
                        if (!clr_cmd && !anim_busy) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_HOLD;
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with short debounce (4) and auto period (16).
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_raw;
    logic       selec;
    logic       auto_en;
    logic       anim_busy;
    logic [7:0] count_in;
    logic       inc_cmd;
    logic       clr_cmd;
    logic       count_reached;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int clr_cnt  = 0;
    int rch_cnt  = 0;

    step_sequencer #(
        .WIDTH(8), .STEP(10), .LIMIT(150), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(16)
    ) dut (
        .clk(clk), .reset(reset), .button_raw(button_raw), .selec(selec),
        .auto_en(auto_en), .anim_busy(anim_busy), .count_in(count_in),
        .inc_cmd(inc_cmd), .clr_cmd(clr_cmd), .count_reached(count_reached), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (inc_cmd) inc_cnt++;
        if (clr_cmd) clr_cnt++;
        if (count_reached) rch_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int c0, i0;
        reset = 1'b0; button_raw = 1'b0; selec = 1'b1; auto_en = 1'b0;
        anim_busy = 1'b0; count_in = 8'd40;
        cycles(3);
        n_checks++;
        if (state !== 2'd0 || inc_cmd !== 1'b0 || clr_cmd !== 1'b0 || count_reached !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d inc=%b clr=%b reached=%b, required state=0 and all pulses 0",
                     state, inc_cmd, clr_cmd, count_reached);
        end
        c0 = clr_cnt; i0 = inc_cnt;
        reset = 1'b1;
        cycles(1);
        n_checks++;
        if (state !== 2'd0 || clr_cmd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_clr: state=%0d clr=%b, required state=0 clr=1", state, clr_cmd);
        end
        cycles(1);
        n_checks++;
        if (state !== 2'd1 || clr_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle: state=%0d clr=%b, required state=1 clr=0", state, clr_cmd);
        end
        cycles(6);
        n_checks++;
        if (clr_cnt - c0 != 1 || inc_cnt - i0 != 0) begin
            n_fail++;
            $display("FAIL reset_pulse_count: clr=%0d inc=%0d, required clr=1 inc=0", clr_cnt - c0, inc_cnt - i0);
        end
    endtask

    task automatic test_debounce;
        int i0, lat;
        bit found;
        count_in = 8'd40;
        i0 = inc_cnt; lat = 0; found = 1'b0;
        button_raw = 1'b1;
        for (int i = 1; i <= 20 && !found; i++) begin
            cycles(1);
            if (inc_cmd === 1'b1) begin
                found = 1'b1;
                lat = i;
            end
        end
        n_checks++;
        if (!found || lat != 7) begin
            n_fail++;
            $display("FAIL debounce_latency: found=%0d latency=%0d, required latency=7", found, lat);
        end
        n_checks++;
        if (state !== 2'd2 || clr_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_state: state=%0d clr=%b, required state=2 clr=0", state, clr_cmd);
        end
        cycles(1);
        n_checks++;
        if (state !== 2'd2 || inc_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_second_cycle: state=%0d inc=%b, required state=2 inc=0", state, inc_cmd);
        end
        cycles(1);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL settle_to_idle: state=%0d, required 1", state);
        end
        cycles(1);
        button_raw = 1'b0;
        cycles(12);
        n_checks++;
        if (inc_cnt - i0 != 1) begin
            n_fail++;
            $display("FAIL single_inc_per_press: inc=%0d, required 1", inc_cnt - i0);
        end
        i0 = inc_cnt;
        button_raw = 1'b1;
        cycles(2);
        button_raw = 1'b0;
        cycles(15);
        n_checks++;
        if (inc_cnt - i0 != 0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL glitch_rejected: inc=%0d state=%0d, required inc=0 state=1", inc_cnt - i0, state);
        end
    endtask

    task automatic test_limit_boundary;
        count_in = 8'd149;
        button_raw = 1'b1;
        cycles(7);
        n_checks++;
        if (inc_cmd !== 1'b1 || clr_cmd !== 1'b0 || count_reached !== 1'b0) begin
            n_fail++;
            $display("FAIL below_limit: inc=%b clr=%b reached=%b, required inc=1 clr=0 reached=0",
                     inc_cmd, clr_cmd, count_reached);
        end
        cycles(3);
        button_raw = 1'b0;
        cycles(12);
        count_in = 8'd40;
    endtask

    task automatic test_celebrate;
        int i0, c0, r0;
        count_in = 8'd150;
        i0 = inc_cnt; c0 = clr_cnt; r0 = rch_cnt;
        button_raw = 1'b1;
        cycles(7);
        n_checks++;
        if (clr_cmd !== 1'b1 || count_reached !== 1'b1 || inc_cmd !== 1'b0 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL limit_wrap: clr=%b reached=%b inc=%b state=%0d, required clr=1 reached=1 inc=0 state=3",
                     clr_cmd, count_reached, inc_cmd, state);
        end
        button_raw = 1'b0;
        anim_busy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycles(1);
            if (i == 5) button_raw = 1'b1;
            if (i == 13) button_raw = 1'b0;
            n_checks++;
            if (state !== 2'd3) begin
                n_fail++;
                $display("FAIL celebrate_hold: busy cycle %0d state=%0d, required 3", i, state);
            end
        end
        anim_busy = 1'b0;
        cycles(1);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL celebrate_exit: state=%0d, required 1", state);
        end
        n_checks++;
        if (inc_cnt - i0 != 0 || clr_cnt - c0 != 1 || rch_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL celebrate_pulses: inc=%0d clr=%0d reached=%0d, required 0 1 1",
                     inc_cnt - i0, clr_cnt - c0, rch_cnt - r0);
        end
        count_in = 8'd0;
        cycles(4);
    endtask

    task automatic test_auto;
        bit exp_inc;
        count_in = 8'd0;
        auto_en = 1'b1;
        for (int i = 1; i <= 75; i++) begin
            cycles(1);
            if (i == 45) button_raw = 1'b1;
            if (i == 55) button_raw = 1'b0;
            exp_inc = (i == 16 || i == 34 || i == 52 || i == 70);
            n_checks++;
            if (inc_cmd !== exp_inc) begin
                n_fail++;
                $display("FAIL auto_tick: cycle %0d inc=%b, required %b", i, inc_cmd, exp_inc);
            end
        end
        auto_en = 1'b0;
        cycles(12);
    endtask

    task automatic test_selec_drop;
        int i0, c0;
        count_in = 8'd40;
        button_raw = 1'b1;
        cycles(7);
        n_checks++;
        if (inc_cmd !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_drop_inc: inc=%b state=%0d, required inc=1 state=2", inc_cmd, state);
        end
        button_raw = 1'b0;
        selec = 1'b0;
        cycles(1);
        n_checks++;
        if (clr_cmd !== 1'b1 || inc_cmd !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL selec_drop: clr=%b inc=%b state=%0d, required clr=1 inc=0 state=0", clr_cmd, inc_cmd, state);
        end
        i0 = inc_cnt; c0 = clr_cnt;
        cycles(12);
        button_raw = 1'b1;
        cycles(10);
        button_raw = 1'b0;
        cycles(10);
        n_checks++;
        if (state !== 2'd0 || inc_cnt - i0 != 0 || clr_cnt - c0 != 0) begin
            n_fail++;
            $display("FAIL hold_ignores_press: state=%0d inc=%0d clr=%0d, required state=0 inc=0 clr=0",
                     state, inc_cnt - i0, clr_cnt - c0);
        end
        selec = 1'b1;
        cycles(1);
        n_checks++;
        if (state !== 2'd1 || clr_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: state=%0d clr=%b, required state=1 clr=0", state, clr_cmd);
        end
        cycles(5);
        n_checks++;
        if (clr_cnt - c0 != 0 || inc_cnt - i0 != 0) begin
            n_fail++;
            $display("FAIL hold_release_pulses: clr=%0d inc=%0d, required 0 0", clr_cnt - c0, inc_cnt - i0);
        end
    endtask

    task automatic test_reset_mid;
        int i0, c0, r0;
        count_in = 8'd200;
        button_raw = 1'b1;
        cycles(7);
        n_checks++;
        if (clr_cmd !== 1'b1 || count_reached !== 1'b1 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL out_of_range_wrap: clr=%b reached=%b state=%0d, required clr=1 reached=1 state=3",
                     clr_cmd, count_reached, state);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (inc_cmd !== 1'b0 || clr_cmd !== 1'b0 || count_reached !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_immediate: inc=%b clr=%b reached=%b state=%0d, required all 0",
                     inc_cmd, clr_cmd, count_reached, state);
        end
        button_raw = 1'b0;
        count_in = 8'd0;
        cycles(3);
        i0 = inc_cnt; c0 = clr_cnt; r0 = rch_cnt;
        reset = 1'b1;
        cycles(8);
        n_checks++;
        if (clr_cnt - c0 != 1 || rch_cnt - r0 != 0 || inc_cnt - i0 != 0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_recovery: clr=%0d reached=%0d inc=%0d state=%0d, required 1 0 0 state=1",
                     clr_cnt - c0, rch_cnt - r0, inc_cnt - i0, state);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_limit_boundary();
        test_celebrate();
        test_auto();
        test_selec_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
